ben_multi_ctx: RTL and testbench
================================

// Module: ben_multi_ctx
// PURPOSE
//  Parametrised LC-3 branch-enable unit with N_CTX independent NZP condition-code contexts
//  (one per hardware thread/context). Flags are loaded from the bus and branch conditions
//  (IR[11:9]) are evaluated against a selected context; optional same-cycle forwarding.
//  Result leaves through a 1-deep valid/ready output register.
//  Per-context taken/total branch statistics. Sits between datapath bus and control FSM.
// PARAMETERS
//  WIDTH   16  bus width; sign bit is Bus[WIDTH-1]
//  N_CTX   4   number of NZP contexts; power of two, >=2
//  BYPASS  1   1: forward same-cycle LD_CC flags to an evaluation of the same context
//  CNT_W   8   width of each statistics counter
// PORTS
//  Clk         in   1       clock, rising edge
//  Reset_n     in   1       asynchronous, active-low reset
//  Bus         in   WIDTH   value whose sign/zero sets the flags
//  LD_CC       in   1       write computed NZP into context CC_Ctx this cycle
//  CC_Ctx      in   CTXW    context written by LD_CC (CTXW = $clog2(N_CTX))
//  Eval_Valid  in   1       evaluation request
//  Eval_Ready  out  1       unit can accept request
//  Eval_Ctx    in   CTXW    context evaluated
//  IR          in   16      instruction; condition mask IR[11:9] = {n,z,p}
//  BEN         out  1       branch-enable result
//  Ben_Valid   out  1       BEN/Ben_Ctx valid
//  Ben_Ready   in   1       consumer accepts result
//  Ben_Ctx     out  CTXW    context of the held result
//  Clr_Stat    in   1       clear both counters of Stat_Ctx
//  Stat_Ctx    in   CTXW    statistics read/clear select
//  Stat_Taken  out  CNT_W   taken count of Stat_Ctx (combinational read)
//  Stat_Total  out  CNT_W   evaluation count of Stat_Ctx (combinational read)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): every nzp[i]=3'b010, BEN=0, Ben_Valid=0, Ben_Ctx=0, all counters 0.
//    Reset mid-stall drops the held result; no partial update survives.
//  - Flag calc: Bus==0 -> 010; else Bus[WIDTH-1] -> 100; else 001. Exactly one-hot.
//  - LD_CC=1: nzp[CC_Ctx] <= calc at posedge. LD_CC=0: all contexts hold.
//  - Eval_Ready = !Ben_Valid | Ben_Ready (accept also in the cycle the held result is drained).
//  - Accept = Eval_Valid & Eval_Ready. nzp_eff = (BYPASS & LD_CC & CC_Ctx==Eval_Ctx) ? calc
//    : nzp[Eval_Ctx]. On accept at edge: BEN <= |(IR[11:9] & nzp_eff), Ben_Ctx <= Eval_Ctx,
//    Ben_Valid <= 1. Latency: 1 cycle from accept to Ben_Valid.
//  - BYPASS=0: evaluation sees the pre-edge nzp; the LD_CC update is visible from the next cycle.
//  - Mask 000 -> BEN=0 always; mask 111 -> BEN=1 always.
//  - No accept & Ben_Ready & Ben_Valid -> Ben_Valid <= 0. While Ben_Valid & !Ben_Ready:
//    BEN, Ben_Ctx held stable, no accept.
//  - Stats on accept: total[Eval_Ctx]++; taken[Eval_Ctx]++ if the new BEN=1.
//    Once total reaches 2^CNT_W-1 both counters of that context freeze (taken<=total always).
//  - Clr_Stat: both counters of Stat_Ctx <= 0. Clear wins over a same-cycle increment of the same
//    context. Other contexts keep counting.
//  - Simultaneous LD_CC and eval on different contexts: independent, no interaction.
// STRUCTURE
//  - Package lc3_cc_pkg: typedef logic [2:0] nzp_t; localparam nzp_t NZP_RESET=3'b010;
//    function nzp_t calc_nzp(bus) (WIDTH-generic via parameterised call site).
//  - Sub-module ben_stat_ctr: one taken/total saturating/freezing counter pair with inc, taken, clr.
//    Instanced N_CTX times in a generate loop.
//  - Top: nzp register array, forwarding mux, output register + handshake.
// TESTING
//  1. Reset, no LD_CC; eval ctx0 IR[11:9]=010 -> BEN=1 next cycle; mask 101 -> BEN=0; all stats 0.
//  2. LD_CC ctx2 Bus=16'h8000, then eval ctx2 mask 100 -> BEN=1; eval ctx1 mask 100 -> BEN=0 (ctx1 still Z).
//  3. Same cycle LD_CC ctx3 Bus=16'h0005 + eval ctx3 mask 001 -> BEN=1 (BYPASS=1); BYPASS=0 -> BEN=0.
//  4. Ben_Ready=0 for 3 cycles with Eval_Valid=1 -> Eval_Ready=0, BEN/Ben_Ctx stable, total unchanged;
//     Ben_Ready=1 -> drain and new accept same cycle.
//  5. CNT_W=4: 20 taken evals ctx1 -> Stat_Total=15, Stat_Taken=15 frozen; Clr_Stat with eval ctx1 -> both 0.
//  6. Assert Reset_n low between edges while Ben_Valid=1 -> Ben_Valid=0, nzp=010 immediately.

Source files
------------

// File: rtl/lc3_cc_pkg.sv
// Shared types and the NZP flag computation for the LC-3 branch-enable unit.
package lc3_cc_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  // Width-independent: the caller reduces its bus to zero/sign bits.
  function automatic nzp_t calc_nzp(input logic is_zero, input logic sign);
    if (is_zero)   return 3'b010;
    else if (sign) return 3'b100;
    else           return 3'b001;
  endfunction

endpackage

// File: rtl/ben_stat_ctr.sv
// One taken/total statistics counter pair. Both freeze once total saturates,
// which keeps taken <= total. Clear has priority over an increment.
module ben_stat_ctr
  import lc3_cc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             taken,
  input  logic             clr,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counter pair update: clear, else count until total is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (clr) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (inc && (total_cnt != CNT_MAX)) begin
      total_cnt <= total_cnt + 1'b1;
      if (taken) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ben_multi_ctx.sv
// LC-3 branch-enable unit with per-context NZP flags, optional same-cycle
// flag forwarding, a one-deep valid/ready result register and per-context
// taken/total statistics.
module ben_multi_ctx
  import lc3_cc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N_CTX  = 4,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 8,
  localparam int CTXW  = $clog2(N_CTX)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Bus,
  input  logic             LD_CC,
  input  logic [CTXW-1:0]  CC_Ctx,
  input  logic             Eval_Valid,
  output logic             Eval_Ready,
  input  logic [CTXW-1:0]  Eval_Ctx,
  input  logic [15:0]      IR,
  output logic             BEN,
  output logic             Ben_Valid,
  input  logic             Ben_Ready,
  output logic [CTXW-1:0]  Ben_Ctx,
  input  logic             Clr_Stat,
  input  logic [CTXW-1:0]  Stat_Ctx,
  output logic [CNT_W-1:0] Stat_Taken,
  output logic [CNT_W-1:0] Stat_Total
);

  localparam bit BYP = (BYPASS != 0);

  nzp_t             nzp_q [N_CTX];
  nzp_t             nzp_calc;
  nzp_t             nzp_eff;
  logic             fwd;
  logic             accept;
  logic             ben_next;
  logic [CNT_W-1:0] taken_arr [N_CTX];
  logic [CNT_W-1:0] total_arr [N_CTX];
  logic             unused_ir;

  assign unused_ir = ^{IR[15:12], IR[8:0]};

  assign nzp_calc   = calc_nzp(Bus == '0, Bus[WIDTH-1]);
  assign fwd        = BYP && LD_CC && (CC_Ctx == Eval_Ctx);
  assign nzp_eff    = fwd ? nzp_calc : nzp_q[Eval_Ctx];
  assign ben_next   = |(IR[11:9] & nzp_eff);
  assign Eval_Ready = !Ben_Valid || Ben_Ready;
  assign accept     = Eval_Valid && Eval_Ready;

  // Condition-code registers, one per context.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_CTX; i++) nzp_q[i] <= NZP_RESET;
    end else if (LD_CC) begin
      nzp_q[CC_Ctx] <= nzp_calc;
    end
  end

  // Result register: load on accept, drop valid when drained with nothing new.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BEN       <= 1'b0;
      Ben_Ctx   <= '0;
      Ben_Valid <= 1'b0;
    end else if (accept) begin
      BEN       <= ben_next;
      Ben_Ctx   <= Eval_Ctx;
      Ben_Valid <= 1'b1;
    end else if (Ben_Ready) begin
      Ben_Valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CTX; g++) begin : g_stat
    ben_stat_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .inc       (accept && (Eval_Ctx == CTXW'(g))),
      .taken     (ben_next),
      .clr       (Clr_Stat && (Stat_Ctx == CTXW'(g))),
      .taken_cnt (taken_arr[g]),
      .total_cnt (total_arr[g])
    );
  end

  assign Stat_Taken = taken_arr[Stat_Ctx];
  assign Stat_Total = total_arr[Stat_Ctx];

endmodule

// File: tb/tb_ben_multi_ctx.sv
// Directed bench: main DUT (BYPASS=1, CNT_W=4) plus a BYPASS=0 twin on the
// same inputs for the forwarding comparison.
module tb_ben_multi_ctx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus = '0;
  logic        ld_cc = 1'b0;
  logic [1:0]  cc_ctx = '0;
  logic        eval_valid = 1'b0;
  logic [1:0]  eval_ctx = '0;
  logic [15:0] ir = '0;
  logic        ben_ready = 1'b1;
  logic        clr_stat = 1'b0;
  logic [1:0]  stat_ctx = '0;

  logic        eval_ready, ben, ben_valid;
  logic [1:0]  ben_ctx;
  logic [3:0]  stat_taken, stat_total;

  logic        eval_ready_nb, ben_nb, ben_valid_nb;
  logic [1:0]  ben_ctx_nb;
  logic [3:0]  stat_taken_nb, stat_total_nb;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ben_multi_ctx #(.WIDTH(16), .N_CTX(4), .BYPASS(1), .CNT_W(4)) dut (
    .Clk(clk), .Reset_n(rst_n), .Bus(bus), .LD_CC(ld_cc), .CC_Ctx(cc_ctx),
    .Eval_Valid(eval_valid), .Eval_Ready(eval_ready), .Eval_Ctx(eval_ctx), .IR(ir),
    .BEN(ben), .Ben_Valid(ben_valid), .Ben_Ready(ben_ready), .Ben_Ctx(ben_ctx),
    .Clr_Stat(clr_stat), .Stat_Ctx(stat_ctx), .Stat_Taken(stat_taken), .Stat_Total(stat_total)
  );

  ben_multi_ctx #(.WIDTH(16), .N_CTX(4), .BYPASS(0), .CNT_W(4)) dut_nb (
    .Clk(clk), .Reset_n(rst_n), .Bus(bus), .LD_CC(ld_cc), .CC_Ctx(cc_ctx),
    .Eval_Valid(eval_valid), .Eval_Ready(eval_ready_nb), .Eval_Ctx(eval_ctx), .IR(ir),
    .BEN(ben_nb), .Ben_Valid(ben_valid_nb), .Ben_Ready(ben_ready), .Ben_Ctx(ben_ctx_nb),
    .Clr_Stat(clr_stat), .Stat_Ctx(stat_ctx), .Stat_Taken(stat_taken_nb), .Stat_Total(stat_total_nb)
  );

  typedef struct {
    logic        ld;
    logic [1:0]  cc;
    logic [15:0] bus;
    logic        ev;
    logic [1:0]  ectx;
    logic [2:0]  mask;
    logic        exp_valid;
    logic        exp_ben;
    logic [1:0]  exp_ctx;
    logic        exp_ben_nb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eval(input logic ev, input logic [1:0] ctx, input logic [2:0] mask);
    eval_valid = ev;
    eval_ctx   = ctx;
    ir         = {4'hA, mask, 9'h155};
  endtask

  task automatic check_stat(input string name, input logic [1:0] ctx, input int tk, input int tot);
    stat_ctx = ctx;
    #1;
    check({name, " taken"}, int'(stat_taken), tk);
    check({name, " total"}, int'(stat_total), tot);
  endtask

  initial begin
    //          ld  cc   bus       ev  ectx mask    v  ben ctx nb
    vecs[0]  = '{0, 2'd0, 16'h0000, 1, 2'd0, 3'b010, 1, 1, 2'd0, 1};
    vecs[1]  = '{0, 2'd0, 16'h0000, 1, 2'd0, 3'b101, 1, 0, 2'd0, 0};
    vecs[2]  = '{1, 2'd2, 16'h8000, 0, 2'd0, 3'b000, 0, 0, 2'd0, 0};
    vecs[3]  = '{0, 2'd0, 16'h0000, 1, 2'd2, 3'b100, 1, 1, 2'd2, 1};
    vecs[4]  = '{0, 2'd0, 16'h0000, 1, 2'd1, 3'b100, 1, 0, 2'd1, 0};
    vecs[5]  = '{1, 2'd3, 16'h0005, 1, 2'd3, 3'b001, 1, 1, 2'd3, 0};
    vecs[6]  = '{0, 2'd0, 16'h0000, 1, 2'd3, 3'b001, 1, 1, 2'd3, 1};
    vecs[7]  = '{1, 2'd1, 16'hFFFF, 1, 2'd2, 3'b111, 1, 1, 2'd2, 1};
    vecs[8]  = '{0, 2'd0, 16'h0000, 1, 2'd2, 3'b000, 1, 0, 2'd2, 0};
    vecs[9]  = '{1, 2'd0, 16'h7FFF, 1, 2'd0, 3'b001, 1, 1, 2'd0, 0};
    vecs[10] = '{0, 2'd0, 16'h0000, 1, 2'd0, 3'b011, 1, 1, 2'd0, 1};
    vecs[11] = '{0, 2'd0, 16'h0000, 1, 2'd1, 3'b100, 1, 1, 2'd1, 1};

    // Reset state
    #12;
    rst_n = 1'b1;
    #1;
    check("rst ben_valid", int'(ben_valid), 0);
    check("rst ben", int'(ben), 0);
    check("rst ben_ctx", int'(ben_ctx), 0);
    check("rst eval_ready", int'(eval_ready), 1);
    for (int c = 0; c < 4; c++) check_stat($sformatf("rst stat%0d", c), 2'(c), 0, 0);

    // Table-driven vectors, consumer always ready
    ben_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ld_cc  = vecs[i].ld;
      cc_ctx = vecs[i].cc;
      bus    = vecs[i].bus;
      set_eval(vecs[i].ev, vecs[i].ectx, vecs[i].mask);
      step();
      check($sformatf("vec%0d valid", i), int'(ben_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d ben", i), int'(ben), int'(vecs[i].exp_ben));
        check($sformatf("vec%0d ctx", i), int'(ben_ctx), int'(vecs[i].exp_ctx));
        check($sformatf("vec%0d ben_nobyp", i), int'(ben_nb), int'(vecs[i].exp_ben_nb));
      end
    end
    ld_cc = 1'b0;
    bus   = '0;
    check_stat("tbl stat0", 2'd0, 3, 4);
    check_stat("tbl stat1", 2'd1, 1, 2);
    check_stat("tbl stat2", 2'd2, 2, 3);
    check_stat("tbl stat3", 2'd3, 2, 2);

    // Backpressure: hold result for 3 cycles, then drain and accept together
    set_eval(1'b0, 2'd0, 3'b000);
    step();
    check("drain valid", int'(ben_valid), 0);
    ben_ready = 1'b0;
    set_eval(1'b1, 2'd3, 3'b001);
    step();
    check("stall load valid", int'(ben_valid), 1);
    check("stall load ben", int'(ben), 1);
    set_eval(1'b1, 2'd0, 3'b000);
    stat_ctx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d eval_ready", k), int'(eval_ready), 0);
      step();
      check($sformatf("stall%0d valid", k), int'(ben_valid), 1);
      check($sformatf("stall%0d ben", k), int'(ben), 1);
      check($sformatf("stall%0d ctx", k), int'(ben_ctx), 3);
      check($sformatf("stall%0d total0", k), int'(stat_total), 4);
    end
    ben_ready = 1'b1;
    #1;
    check("unstall eval_ready", int'(eval_ready), 1);
    step();
    check("unstall valid", int'(ben_valid), 1);
    check("unstall ben", int'(ben), 0);
    check("unstall ctx", int'(ben_ctx), 0);
    set_eval(1'b0, 2'd0, 3'b000);
    check_stat("unstall stat0", 2'd0, 3, 5);
    check_stat("unstall stat3", 2'd3, 3, 3);

    // Saturation on ctx1 (ctx1 holds N), then clear
    stat_ctx = 2'd1;
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    check_stat("clr1", 2'd1, 0, 0);
    set_eval(1'b1, 2'd1, 3'b100);
    for (int k = 0; k < 20; k++) step();
    set_eval(1'b0, 2'd0, 3'b000);
    check_stat("sat1", 2'd1, 15, 15);
    clr_stat = 1'b1;
    set_eval(1'b1, 2'd1, 3'b100);
    step();
    clr_stat = 1'b0;
    set_eval(1'b0, 2'd0, 3'b000);
    check("clr+eval ben", int'(ben), 1);
    check_stat("clr+eval stat1", 2'd1, 0, 0);
    stat_ctx = 2'd0;
    clr_stat = 1'b1;
    set_eval(1'b1, 2'd2, 3'b111);
    step();
    clr_stat = 1'b0;
    set_eval(1'b0, 2'd0, 3'b000);
    check_stat("clr other stat0", 2'd0, 0, 0);
    check_stat("clr other stat2", 2'd2, 3, 4);

    // Asynchronous reset while a result is held
    ben_ready = 1'b0;
    step();
    set_eval(1'b1, 2'd2, 3'b100);
    step();
    set_eval(1'b0, 2'd0, 3'b000);
    check("pre-rst valid", int'(ben_valid), 1);
    check("pre-rst ctx", int'(ben_ctx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", int'(ben_valid), 0);
    check("async rst ben", int'(ben), 0);
    check("async rst ctx", int'(ben_ctx), 0);
    check_stat("async rst stat2", 2'd2, 0, 0);
    rst_n = 1'b1;
    ben_ready = 1'b1;
    set_eval(1'b1, 2'd2, 3'b010);
    step();
    check("post-rst z ben", int'(ben), 1);
    set_eval(1'b1, 2'd2, 3'b100);
    step();
    check("post-rst n ben", int'(ben), 0);
    set_eval(1'b0, 2'd0, 3'b000);
    check_stat("post-rst stat2", 2'd2, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
